// File: rtl/rs_ctrl_relay_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rs_ctrl_relay_pkg
//  Purpose  : Shared types and helpers for the relay-station token pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
package rs_ctrl_relay_pkg;

   // Entries held by a single relay station (skid buffer depth).
   localparam int STATION_DEPTH = 2;

   // Occupancy state of one relay station.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } station_state_t;

   // Width of the in-flight counter: must represent 0..STATION_DEPTH*levels.
   function automatic int cnt_width(input int levels);
      return $clog2(STATION_DEPTH * levels + 2);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rs_relay_station.sv
`default_nettype none
// ============================================================================
//  Module   : rs_relay_station
//  Purpose  : One 2-entry skid buffer. Ready (o_full_n) is registered so the
//             downstream read never reaches the upstream ready combinationally.
//  Revision : 1.0 - initial release
// ============================================================================
module rs_relay_station
   import rs_ctrl_relay_pkg::*;
#(
   parameter int DATA_WIDTH = 1
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_write,
   input  logic [DATA_WIDTH-1:0] i_din,
   output logic                  o_full_n,
   output logic                  o_empty_n,
   output logic [DATA_WIDTH-1:0] o_dout,
   input  logic                  i_read
);

   station_state_t        r_state;
   station_state_t        w_state_nxt;
   logic                  r_full_n;
   logic [DATA_WIDTH-1:0] r_data0;      // head entry, drives o_dout
   logic [DATA_WIDTH-1:0] r_data1;      // skid entry, only valid in TWO
   logic [DATA_WIDTH-1:0] w_data0_nxt;
   logic [DATA_WIDTH-1:0] w_data1_nxt;
   logic                  w_push;
   logic                  w_pop;

   assign w_push = i_write & r_full_n;
   assign w_pop  = i_read & (r_state != EMPTY);

   // Next-state and next-data selection for the skid buffer.
   always_comb begin
      w_state_nxt = r_state;
      w_data0_nxt = r_data0;
      w_data1_nxt = r_data1;
      case (r_state)
         EMPTY: begin
            if (w_push) begin
               w_state_nxt = ONE;
               w_data0_nxt = i_din;
            end
         end
         ONE: begin
            if (w_push && !w_pop) begin
               w_state_nxt = TWO;
               w_data1_nxt = i_din;
            end else if (w_pop && !w_push) begin
               w_state_nxt = EMPTY;
            end else if (w_push && w_pop) begin
               w_data0_nxt = i_din;
            end
         end
         TWO: begin
            // r_full_n is low here, so w_push cannot occur.
            if (w_pop) begin
               w_state_nxt = ONE;
               w_data0_nxt = r_data1;
            end
         end
         default: begin
            w_state_nxt = EMPTY;
         end
      endcase
   end

   // State, registered ready and payload storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= EMPTY;
         r_full_n <= 1'b0;
         r_data0  <= '0;
         r_data1  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_full_n <= (w_state_nxt != TWO);
         r_data0  <= w_data0_nxt;
         r_data1  <= w_data1_nxt;
      end
   end

   assign o_full_n  = r_full_n;
   assign o_empty_n = (r_state != EMPTY);
   assign o_dout    = r_data0;

endmodule
`default_nettype wire

// File: rtl/rs_ctrl_relay_pipeline.sv
`default_nettype none
// ============================================================================
//  Module   : rs_ctrl_relay_pipeline
//  Purpose  : FIFO-style token pipeline of LEVELS relay stations with an
//             in-flight token count and a drain-detect idle flag.
//             Optional macro RS_CTRL_RELAY_STATS_EN adds xfer_count and
//             stall_seen outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module rs_ctrl_relay_pipeline
   import rs_ctrl_relay_pkg::*;
#(
   parameter int DATA_WIDTH   = 1,
   parameter int LEVELS       = 2,
   parameter int GRACE_PERIOD = 2 * LEVELS,
   parameter int CNT_W        = cnt_width(LEVELS)
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] if_din,
   input  logic                  if_write,
   output logic                  if_full_n,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic                  if_empty_n,
   input  logic                  if_read,
   output logic [CNT_W-1:0]      inflight,
   output logic                  idle
`ifdef RS_CTRL_RELAY_STATS_EN
   ,
   output logic [31:0]           xfer_count,
   output logic                  stall_seen
`endif
);

   // A zero grace period would make the counter zero-width; treat it as 1.
   localparam int c_GRACE   = (GRACE_PERIOD < 1) ? 1 : GRACE_PERIOD;
   localparam int c_GRACE_W = $clog2(c_GRACE + 1);

   logic                 w_push;
   logic                 w_pop;
   logic                 w_quiet;
   logic [c_GRACE_W-1:0] r_grace;
   logic                 r_idle;

   assign w_push = if_write & if_full_n;
   assign w_pop  = if_read & if_empty_n;

   generate
      if (LEVELS > 0) begin : g_chain
         // Index k is the boundary in front of station k; index LEVELS is
         // the downstream interface.
         logic [DATA_WIDTH-1:0] w_dat [0:LEVELS];
         logic                  w_vld [0:LEVELS];
         logic                  w_rdy [0:LEVELS];
         logic [CNT_W-1:0]      r_inflight;

         assign w_dat[0]      = if_din;
         assign w_vld[0]      = if_write;
         assign w_rdy[LEVELS] = if_read;

         for (genvar k = 0; k < LEVELS; k++) begin : g_station
            rs_relay_station #(
               .DATA_WIDTH (DATA_WIDTH)
            ) u_station (
               .clk       (clk),
               .rst       (reset),
               .i_write   (w_vld[k]),
               .i_din     (w_dat[k]),
               .o_full_n  (w_rdy[k]),
               .o_empty_n (w_vld[k+1]),
               .o_dout    (w_dat[k+1]),
               .i_read    (w_rdy[k+1])
            );
         end

         assign if_full_n  = w_rdy[0];
         assign if_empty_n = w_vld[LEVELS];
         assign if_dout    = w_dat[LEVELS];

         // Token occupancy: up on accepted push, down on accepted pop.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_inflight <= '0;
            end else if (w_push && !w_pop) begin
               r_inflight <= r_inflight + CNT_W'(1);
            end else if (w_pop && !w_push) begin
               r_inflight <= r_inflight - CNT_W'(1);
            end
         end

         assign inflight = r_inflight;
      end else begin : g_pass
         // No stations: the interface is a plain wire-through.
         assign if_dout    = if_din;
         assign if_empty_n = if_write;
         assign if_full_n  = if_read;
         assign inflight   = '0;
      end
   endgenerate

   assign w_quiet = (inflight == '0) && !if_write;

   // Grace counter saturates at c_GRACE while quiet; idle is raised one
   // edge after saturation and drops on the first non-quiet edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_grace <= '0;
         r_idle  <= 1'b0;
      end else begin
         if (!w_quiet) begin
            r_grace <= '0;
         end else if (r_grace != c_GRACE_W'(c_GRACE)) begin
            r_grace <= r_grace + c_GRACE_W'(1);
         end
         r_idle <= w_quiet && (r_grace == c_GRACE_W'(c_GRACE));
      end
   end

   assign idle = r_idle;

`ifdef RS_CTRL_RELAY_STATS_EN
   logic [31:0] r_xfer_count;
   logic        r_stall_seen;

   // Wrapping pop counter and sticky upstream-stall flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_xfer_count <= '0;
         r_stall_seen <= 1'b0;
      end else begin
         if (w_pop) begin
            r_xfer_count <= r_xfer_count + 32'd1;
         end
         if (if_write && !if_full_n) begin
            r_stall_seen <= 1'b1;
         end
      end
   end

   assign xfer_count = r_xfer_count;
   assign stall_seen = r_stall_seen;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rs_ctrl_relay_pipeline.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rs_ctrl_relay_pipeline
//  Purpose  : Directed bench for rs_ctrl_relay_pipeline: a LEVELS=2 instance
//             driven from a vector table, a LEVELS=3 instance for latency and
//             mid-operation reset, and a LEVELS=0 passthrough instance.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rs_ctrl_relay_pipeline;

   logic clk;
   logic reset;

   // Instance A: LEVELS=2, GRACE_PERIOD=4
   logic [7:0] a_din, a_dout;
   logic       a_write, a_full_n, a_empty_n, a_read, a_idle;
   logic [2:0] a_inflight;
   // Instance B: LEVELS=3, GRACE_PERIOD default (6)
   logic [7:0] b_din, b_dout;
   logic       b_write, b_full_n, b_empty_n, b_read, b_idle;
   logic [2:0] b_inflight;
   // Instance C: LEVELS=0, GRACE_PERIOD=2
   logic [7:0] c_din, c_dout;
   logic       c_write, c_full_n, c_empty_n, c_read, c_idle;
   logic [0:0] c_inflight;
`ifdef RS_CTRL_RELAY_STATS_EN
   logic [31:0] a_xfer, b_xfer, c_xfer;
   logic        a_stall, b_stall, c_stall;
`endif

   int n_vec  = 0;
   int n_fail = 0;

   rs_ctrl_relay_pipeline #(.DATA_WIDTH(8), .LEVELS(2), .GRACE_PERIOD(4)) dut_a (
      .clk(clk), .reset(reset), .if_din(a_din), .if_write(a_write),
      .if_full_n(a_full_n), .if_dout(a_dout), .if_empty_n(a_empty_n),
      .if_read(a_read), .inflight(a_inflight), .idle(a_idle)
`ifdef RS_CTRL_RELAY_STATS_EN
      , .xfer_count(a_xfer), .stall_seen(a_stall)
`endif
   );

   rs_ctrl_relay_pipeline #(.DATA_WIDTH(8), .LEVELS(3)) dut_b (
      .clk(clk), .reset(reset), .if_din(b_din), .if_write(b_write),
      .if_full_n(b_full_n), .if_dout(b_dout), .if_empty_n(b_empty_n),
      .if_read(b_read), .inflight(b_inflight), .idle(b_idle)
`ifdef RS_CTRL_RELAY_STATS_EN
      , .xfer_count(b_xfer), .stall_seen(b_stall)
`endif
   );

   rs_ctrl_relay_pipeline #(.DATA_WIDTH(8), .LEVELS(0), .GRACE_PERIOD(2)) dut_c (
      .clk(clk), .reset(reset), .if_din(c_din), .if_write(c_write),
      .if_full_n(c_full_n), .if_dout(c_dout), .if_empty_n(c_empty_n),
      .if_read(c_read), .inflight(c_inflight), .idle(c_idle)
`ifdef RS_CTRL_RELAY_STATS_EN
      , .xfer_count(c_xfer), .stall_seen(c_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       wr;
      logic [7:0] din;
      logic       rd;
      logic       full_n;
      logic       empty_n;
      logic       chk_dout;
      logic [7:0] dout;
      logic [2:0] infl;
      logic       idle;
   } vec_t;

   vec_t vec [22];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pushed;

      // Fill/drain on A with a full-pipeline push+pop, then grace behaviour.
      vec[0]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0};
      vec[1]  = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA1, 3'd2, 1'b0};
      vec[2]  = '{1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA1, 3'd3, 1'b0};
      vec[3]  = '{1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 3'd4, 1'b0};
      vec[4]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 3'd4, 1'b0};
      vec[5]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA2, 3'd3, 1'b0};
      vec[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA3, 3'd2, 1'b0};
      vec[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA4, 3'd1, 1'b0};
      vec[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
      for (int i = 9; i <= 12; i++)
         vec[i] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
      vec[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1};
      vec[14] = '{1'b1, 8'hB1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0};
      vec[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'hB1, 3'd1, 1'b0};
      vec[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
      for (int i = 17; i <= 20; i++)
         vec[i] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
      vec[21] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1};

      reset = 1'b0;
      a_din = '0; a_write = 1'b0; a_read = 1'b0;
      b_din = '0; b_write = 1'b0; b_read = 1'b0;
      c_din = '0; c_write = 1'b0; c_read = 1'b0;

      // ---- asynchronous reset values ----
      #1 reset = 1'b1;
      #2;
      check("rst a_full_n",   a_full_n,   0);
      check("rst a_empty_n",  a_empty_n,  0);
      check("rst a_dout",     a_dout,     0);
      check("rst a_inflight", a_inflight, 0);
      check("rst a_idle",     a_idle,     0);
      check("rst b_full_n",   b_full_n,   0);
      @(negedge clk);
      reset = 1'b0;

      // ---- ready rises at edge 1, idle at edge GRACE_PERIOD+1 = 5 ----
      step();
      check("rel a_full_n edge1",  a_full_n,  1);
      check("rel a_empty_n edge1", a_empty_n, 0);
      check("rel a_idle edge1",    a_idle,    0);
      step(); step(); step();
      check("rel a_idle edge4",    a_idle,    0);
      check("rel a_empty_n edge4", a_empty_n, 0);
      step();
      check("rel a_idle edge5",    a_idle,    1);

      // ---- table-driven fill / full push+pop / drain / grace on A ----
      for (int i = 0; i < 22; i++) begin
         a_write = vec[i].wr;
         a_din   = vec[i].din;
         a_read  = vec[i].rd;
         step();
         check($sformatf("row%0d full_n", i),   a_full_n,   vec[i].full_n);
         check($sformatf("row%0d empty_n", i),  a_empty_n,  vec[i].empty_n);
         check($sformatf("row%0d inflight", i), a_inflight, vec[i].infl);
         check($sformatf("row%0d idle", i),     a_idle,     vec[i].idle);
         if (vec[i].chk_dout)
            check($sformatf("row%0d dout", i),  a_dout,     vec[i].dout);
      end
      a_write = 1'b0; a_read = 1'b0; a_din = '0;

      // ---- latency/order on B (LEVELS=3), if_read held high ----
      b_read  = 1'b1;
      b_write = 1'b1; b_din = 8'h11;
      step();
      check("lat b_empty_n +1", b_empty_n, 0);
      check("lat b_inflight +1", b_inflight, 1);
      b_din = 8'h22;
      step();
      check("lat b_empty_n +2", b_empty_n, 0);
      b_din = 8'h33;
      step();
      check("lat b_empty_n +3", b_empty_n, 1);
      check("lat b_dout +3",    b_dout,    8'h11);
      check("lat b_inflight peak", b_inflight, 3);
      b_write = 1'b0; b_din = '0;
      step();
      check("lat b_dout +4",    b_dout,    8'h22);
      check("lat b_inflight +4", b_inflight, 2);
      step();
      check("lat b_dout +5",    b_dout,    8'h33);
      step();
      check("lat b_empty_n +6", b_empty_n, 0);
      check("lat b_inflight +6", b_inflight, 0);

      // ---- mid-operation asynchronous reset on B with 3 tokens held ----
      b_read = 1'b0; b_write = 1'b1;
      for (int i = 0; i < 3; i++) begin
         b_din = 8'h44 + 8'(i);
         step();
      end
      b_write = 1'b0; b_din = '0;
      check("mid b_inflight pre", b_inflight, 3);
      check("mid a_idle pre",     a_idle,     1);
      #2 reset = 1'b1;
      #1;
      check("mid b_empty_n",  b_empty_n,  0);
      check("mid b_inflight", b_inflight, 0);
      check("mid b_full_n",   b_full_n,   0);
      check("mid b_idle",     b_idle,     0);
      check("mid a_idle",     a_idle,     0);
      @(negedge clk);
      reset = 1'b0;
      b_read = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step();
         check($sformatf("post b_empty_n e%0d", i),  b_empty_n,  0);
         check($sformatf("post b_inflight e%0d", i), b_inflight, 0);
         if (i == 4) check("post a_idle e4", a_idle, 0);
         if (i == 5) check("post a_idle e5", a_idle, 1);
      end
      b_read = 1'b0;

      // ---- LEVELS=0 passthrough on C ----
      check("c_idle quiet", c_idle, 1);
      c_din = 8'h5A; c_write = 1'b1; c_read = 1'b0;
      #1;
      check("c_dout",     c_dout,     8'h5A);
      check("c_empty_n",  c_empty_n,  1);
      check("c_full_n lo", c_full_n,  0);
      check("c_inflight", c_inflight, 0);
      c_read = 1'b1;
      #1;
      check("c_full_n hi", c_full_n,  1);
      step();
      check("c_idle after write", c_idle, 0);
      c_write = 1'b0; c_read = 1'b0; c_din = '0;

`ifdef RS_CTRL_RELAY_STATS_EN
      // ---- stats: 10 tokens through A with a forced full-stall ----
      reset = 1'b1;
      #1;
      check("stats xfer rst",  a_xfer,  0);
      check("stats stall rst", a_stall, 0);
      @(negedge clk);
      reset = 1'b0;
      step();
      pushed = 0;
      for (int cyc = 0; cyc < 100 && pushed < 10; cyc++) begin
         a_read  = (cyc >= 6);
         a_write = 1'b1;
         a_din   = 8'(pushed);
         if (a_full_n) pushed++;
         step();
      end
      a_write = 1'b0; a_read = 1'b1;
      check("stats pushed", pushed, 10);
      repeat (12) step();
      a_read = 1'b0;
      check("stats xfer_count", a_xfer,     10);
      check("stats stall_seen", a_stall,    1);
      check("stats inflight",   a_inflight, 0);
      reset = 1'b1;
      #1;
      check("stats stall cleared", a_stall, 0);
      @(negedge clk);
      reset = 1'b0;
`else
      pushed = 0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
